// File: rtl/pipe_mem_pkg.sv
// Shared types and constants for the fetch/LSU memory-port arbiter.
// Optional build macro ARB_RR_EN selects round-robin arbitration.
package pipe_mem_pkg;

  typedef enum logic [2:0] {
    ARB_IDLE    = 3'd0,
    ARB_REQ_IF  = 3'd1,
    ARB_REQ_LS  = 3'd2,
    ARB_WAIT_IF = 3'd3,
    ARB_WAIT_LS = 3'd4
  } arb_state_e;

  localparam logic [0:0] REQ_IF = 1'b0;
  localparam logic [0:0] REQ_LS = 1'b1;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Pick the 32-bit instruction out of a 64-bit line using PC bit 2.
  function automatic logic [31:0] instr_half(input logic sel_hi, input logic [63:0] line);
    logic [31:0] res;
    if (sel_hi) begin
      res = line[63:32];
    end else begin
      res = line[31:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Two-way requester picker for the memory-port arbiter.
// With ARB_RR_EN defined it keeps a last-grant pointer and alternates; otherwise LS wins.
module arb_pick
  import pipe_mem_pkg::*;
(
`ifdef ARB_RR_EN
  input  logic       clk,
  input  logic       rstn,
`endif
  input  logic       idle,
  input  logic       if_valid,
  input  logic       ls_valid,
  input  logic       if_flush,
  output logic [1:0] grant
);

  logic if_ok_s;

  // A flushed fetch is never eligible, whichever policy is built.
  assign if_ok_s = idle & if_valid & ~if_flush;

`ifdef ARB_RR_EN
  logic       last_r;
  logic [1:0] grant_s;

  // Favour the requester that did not win the previous accept.
  always_comb begin
    grant_s = 2'b00;
    if (if_ok_s && (!ls_valid || (last_r == REQ_LS))) begin
      grant_s[REQ_IF] = 1'b1;
    end else if (idle && ls_valid) begin
      grant_s[REQ_LS] = 1'b1;
    end else begin
      grant_s = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      last_r <= REQ_LS;
    end else if (grant_s[REQ_IF]) begin
      last_r <= REQ_IF;
    end else if (grant_s[REQ_LS]) begin
      last_r <= REQ_LS;
    end else begin
      last_r <= last_r;
    end
  end

  assign grant = grant_s;
`else
  always_comb begin
    grant         = 2'b00;
    grant[REQ_LS] = idle & ls_valid;
    grant[REQ_IF] = if_ok_s & ~ls_valid;
  end
`endif

endmodule

// File: rtl/ifu_lsu_mem_arbiter.sv
// Shares one memory port between instruction fetch and the LSU, one transaction in flight.
// Build macro ARB_RR_EN switches the picker from LS-first priority to round-robin.
module ifu_lsu_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_rsp_valid,
  output logic [31:0]       if_rsp_instr,
  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic              ls_req_wen,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [MASK_W-1:0] ls_wmask,
  output logic              ls_rsp_valid,
  output logic [DATA_W-1:0] ls_rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [MASK_W-1:0] mem_wmask,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_rdata,
  output logic              busy
);

  arb_state_e        state_r;
  arb_state_e        state_nxt_s;
  logic [1:0]        grant_s;
  logic              idle_s;
  logic              if_acc_s;
  logic              ls_acc_s;
  logic              rsp_if_s;
  logic              rsp_ls_s;
  logic              if_deliver_s;
  logic              drop_r;
  logic [ADDR_W-1:0] addr_r;
  logic              wen_r;
  logic [DATA_W-1:0] wdata_r;
  logic [MASK_W-1:0] wmask_r;
  logic              if_rsp_valid_r;
  logic              ls_rsp_valid_r;
  logic [31:0]       if_rsp_instr_r;
  logic [DATA_W-1:0] ls_rsp_rdata_r;

  // Readys stay low while reset is applied, even if requesters are asserting valid.
  assign idle_s = rstn & (state_r == ARB_IDLE);

  arb_pick u_pick (
`ifdef ARB_RR_EN
    .clk      (clk),
    .rstn     (rstn),
`endif
    .idle     (idle_s),
    .if_valid (if_req_valid),
    .ls_valid (ls_req_valid),
    .if_flush (if_flush),
    .grant    (grant_s)
  );

  assign if_acc_s     = grant_s[REQ_IF];
  assign ls_acc_s     = grant_s[REQ_LS];
  assign rsp_if_s     = (state_r == ARB_WAIT_IF) & mem_rsp_valid;
  assign rsp_ls_s     = (state_r == ARB_WAIT_LS) & mem_rsp_valid;
  assign if_deliver_s = rsp_if_s & ~drop_r & ~if_flush;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Responses outside WAIT_x are not ours and are ignored.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ARB_IDLE: begin
        if (ls_acc_s) begin
          state_nxt_s = ARB_REQ_LS;
        end else if (if_acc_s) begin
          state_nxt_s = ARB_REQ_IF;
        end else begin
          state_nxt_s = ARB_IDLE;
        end
      end
      ARB_REQ_IF: begin
        if (mem_req_ready) begin
          state_nxt_s = ARB_WAIT_IF;
        end else begin
          state_nxt_s = ARB_REQ_IF;
        end
      end
      ARB_REQ_LS: begin
        if (mem_req_ready) begin
          state_nxt_s = ARB_WAIT_LS;
        end else begin
          state_nxt_s = ARB_REQ_LS;
        end
      end
      ARB_WAIT_IF: begin
        if (mem_rsp_valid) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_WAIT_IF;
        end
      end
      ARB_WAIT_LS: begin
        if (mem_rsp_valid) begin
          state_nxt_s = ARB_IDLE;
        end else begin
          state_nxt_s = ARB_WAIT_LS;
        end
      end
      default: begin
        state_nxt_s = ARB_IDLE;
      end
    endcase
  end

  // Payload is captured once at accept and held stable through REQ_x and WAIT_x.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_r  <= '0;
      wen_r   <= 1'b0;
      wdata_r <= '0;
      wmask_r <= '0;
    end else if (ls_acc_s) begin
      addr_r  <= ls_addr;
      wen_r   <= ls_req_wen;
      wdata_r <= ls_wdata;
      wmask_r <= ls_wmask;
    end else if (if_acc_s) begin
      addr_r  <= if_addr;
      wen_r   <= 1'b0;
      wdata_r <= '0;
      wmask_r <= '0;
    end else begin
      addr_r  <= addr_r;
      wen_r   <= wen_r;
      wdata_r <= wdata_r;
      wmask_r <= wmask_r;
    end
  end

  // A flushed fetch still runs to completion on the memory side; only its response is dropped.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      drop_r <= 1'b0;
    end else if (rsp_if_s) begin
      drop_r <= 1'b0;
    end else if (if_flush && ((state_r == ARB_REQ_IF) || (state_r == ARB_WAIT_IF))) begin
      drop_r <= 1'b1;
    end else begin
      drop_r <= drop_r;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      if_rsp_valid_r <= 1'b0;
      ls_rsp_valid_r <= 1'b0;
      if_rsp_instr_r <= 32'h0000_0000;
      ls_rsp_rdata_r <= '0;
    end else begin
      if_rsp_valid_r <= if_deliver_s;
      ls_rsp_valid_r <= rsp_ls_s;
      if (if_deliver_s) begin
        if_rsp_instr_r <= instr_half(addr_r[2], mem_rsp_rdata);
      end else begin
        if_rsp_instr_r <= if_rsp_instr_r;
      end
      if (rsp_ls_s) begin
        ls_rsp_rdata_r <= wen_r ? '0 : mem_rsp_rdata;
      end else begin
        ls_rsp_rdata_r <= ls_rsp_rdata_r;
      end
    end
  end

  assign if_req_ready  = if_acc_s;
  assign ls_req_ready  = ls_acc_s;
  assign mem_req_valid = (state_r == ARB_REQ_IF) || (state_r == ARB_REQ_LS);
  assign mem_req_wen   = wen_r;
  assign mem_addr      = addr_r;
  assign mem_wdata     = wdata_r;
  assign mem_wmask     = wmask_r;
  assign if_rsp_valid  = if_rsp_valid_r;
  assign if_rsp_instr  = if_rsp_instr_r;
  assign ls_rsp_valid  = ls_rsp_valid_r;
  assign ls_rsp_rdata  = ls_rsp_rdata_r;
  assign busy          = (state_r != ARB_IDLE);

endmodule

// File: tb/tb_ifu_lsu_mem_arbiter.sv
// Directed scoreboard bench for ifu_lsu_mem_arbiter (default LS-first build).
module tb_ifu_lsu_mem_arbiter;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  logic              clk = 1'b0;
  logic              rstn;
  logic              if_req_valid;
  logic              if_req_ready;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [31:0]       if_rsp_instr;
  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_wen;
  logic [ADDR_W-1:0] ls_addr;
  logic [DATA_W-1:0] ls_wdata;
  logic [MASK_W-1:0] ls_wmask;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_rdata;
  logic              mem_req_valid;
  logic              mem_req_ready = 1'b0;
  logic              mem_req_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [MASK_W-1:0] mem_wmask;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_rdata = 64'h0;
  logic              busy;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] if_q[$];
  logic [63:0] ls_q[$];
  logic [63:0] mem_data_q[$];

  int          stall_cfg  = 0;
  int          stall_left = 0;
  int          rsp_lat    = 0;
  int          lat_cnt    = 0;
  int          rsp_count  = 0;
  bit          pend       = 1'b0;
  logic [63:0] pend_data  = 64'h0;

  always #5 clk = ~clk;

  ifu_lsu_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) dut (
    .clk(clk), .rstn(rstn),
    .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
    .if_flush(if_flush), .if_rsp_valid(if_rsp_valid), .if_rsp_instr(if_rsp_instr),
    .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_wen(ls_req_wen),
    .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_wmask(ls_wmask),
    .ls_rsp_valid(ls_rsp_valid), .ls_rsp_rdata(ls_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_wen(mem_req_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model: stalls ready for stall_cfg cycles, answers rsp_lat cycles after the handshake.
  always @(negedge clk) begin
    mem_rsp_valid = 1'b0;
    if (!rstn) begin
      mem_req_ready = 1'b0;
      pend          = 1'b0;
      stall_left    = stall_cfg;
    end else begin
      if (mem_req_ready) begin
        mem_req_ready = 1'b0;
        pend          = 1'b1;
        lat_cnt       = rsp_lat;
        stall_left    = stall_cfg;
        if (mem_data_q.size() > 0) pend_data = mem_data_q.pop_front();
        else pend_data = 64'h0;
      end
      if (pend) begin
        if (lat_cnt == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = pend_data;
          pend          = 1'b0;
          rsp_count++;
        end else begin
          lat_cnt--;
        end
      end else if (mem_req_valid) begin
        if (stall_left == 0) mem_req_ready = 1'b1;
        else stall_left--;
      end
    end
  end

  // Response monitor: every pulse must match the head of its scoreboard queue.
  always @(negedge clk) begin
    if (if_rsp_valid === 1'b1) begin
      if (if_q.size() == 0) chk("if_rsp_unexpected", 64'(if_rsp_valid), 64'h0);
      else chk("if_rsp_instr", 64'(if_rsp_instr), 64'(if_q.pop_front()));
    end
    if (ls_rsp_valid === 1'b1) begin
      if (ls_q.size() == 0) chk("ls_rsp_unexpected", 64'(ls_rsp_valid), 64'h0);
      else chk("ls_rsp_rdata", ls_rsp_rdata, ls_q.pop_front());
    end
  end

  task automatic do_accept(input bit is_ls, input string tag);
    logic rdy;
    rdy = 1'b0;
    for (int k = 0; k < 50; k++) begin
      #1;
      rdy = is_ls ? ls_req_ready : if_req_ready;
      if (rdy) break;
      @(negedge clk);
    end
    chk({tag, "_accept"}, 64'(rdy), 64'h1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_quiet(input string tag);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (!busy && (if_q.size() == 0) && (ls_q.size() == 0)) break;
    end
    chk({tag, "_idle"}, 64'(busy), 64'h0);
    chk({tag, "_drained"}, 64'(if_q.size() + ls_q.size()), 64'h0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'h0);
    chk({tag, "_mem_valid"}, 64'(mem_req_valid), 64'h0);
    chk({tag, "_readys"}, 64'({if_req_ready, ls_req_ready}), 64'h0);
    chk({tag, "_rsp_valids"}, 64'({if_rsp_valid, ls_rsp_valid}), 64'h0);
    chk({tag, "_mem_wen"}, 64'(mem_req_wen), 64'h0);
    chk({tag, "_mem_addr"}, mem_addr, 64'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 64'h0);
    chk({tag, "_mem_wmask"}, 64'(mem_wmask), 64'h0);
    chk({tag, "_if_instr"}, 64'(if_rsp_instr), 64'h0);
    chk({tag, "_ls_rdata"}, ls_rsp_rdata, 64'h0);
  endtask

  initial begin
    int prev_rsp;
    int gap;
    rstn = 1'b0; if_req_valid = 1'b1; ls_req_valid = 1'b1; if_flush = 1'b0;
    if_addr = 64'h0; ls_req_wen = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h00;
    repeat (3) @(negedge clk);
    #1;
    chk_all_zero("reset");
    if_req_valid = 1'b0; ls_req_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;

    // Single fetch from an odd word: upper half returned.
    rsp_lat = 1;
    mem_data_q.push_back(64'h1111_2222_3333_4444);
    if_q.push_back(32'h1111_2222);
    @(negedge clk);
    if_addr = 64'h8000_0004; if_req_valid = 1'b1;
    do_accept(1'b0, "if1");
    if_req_valid = 1'b0; if_addr = 64'h0;
    chk("if1_mem_valid", 64'(mem_req_valid), 64'h1);
    chk("if1_mem_addr", mem_addr, 64'h8000_0004);
    chk("if1_mem_wen", 64'(mem_req_wen), 64'h0);
    wait_quiet("if1");

    // LS write with memory stalling ready for 3 cycles; write ack returns zero data.
    rsp_lat = 0; stall_cfg = 3; stall_left = 3;
    mem_data_q.push_back(64'hFFFF_FFFF_FFFF_FFFF);
    ls_q.push_back(64'h0);
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_wen = 1'b1; ls_addr = 64'h8000_1000;
    ls_wdata = 64'h0000_0000_DEAD_BEEF; ls_wmask = 8'h0F;
    do_accept(1'b1, "lsw");
    ls_req_valid = 1'b0; ls_req_wen = 1'b0; ls_addr = 64'h0; ls_wdata = 64'h0; ls_wmask = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("lsw_mem_valid", 64'(mem_req_valid), 64'h1);
      chk("lsw_mem_wen", 64'(mem_req_wen), 64'h1);
      chk("lsw_mem_addr", mem_addr, 64'h8000_1000);
      chk("lsw_mem_wdata", mem_wdata, 64'h0000_0000_DEAD_BEEF);
      chk("lsw_mem_wmask", 64'(mem_wmask), 64'h0F);
    end
    stall_cfg = 0;
    wait_quiet("lsw");

    // Contention: LS read wins, pending IF follows once LS completes.
    mem_data_q.push_back(64'hCAFE_F00D_1234_5678);
    mem_data_q.push_back(64'h9999_8888_7777_6666);
    ls_q.push_back(64'hCAFE_F00D_1234_5678);
    if_q.push_back(32'h7777_6666);
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_addr = 64'h8000_2000;
    if_req_valid = 1'b1; if_addr = 64'h8000_0010;
    #1;
    chk("arb_ls_ready", 64'(ls_req_ready), 64'h1);
    chk("arb_if_blocked", 64'(if_req_ready), 64'h0);
    do_accept(1'b1, "arb_ls");
    ls_req_valid = 1'b0;
    do_accept(1'b0, "arb_if");
    if_req_valid = 1'b0;
    chk("arb_ls_first", 64'(ls_q.size()), 64'h0);
    wait_quiet("arb");

    // Flush in IDLE blocks the grant; flush in WAIT_IF drops the response.
    rsp_lat = 2; prev_rsp = rsp_count;
    mem_data_q.push_back(64'h5555_5555_6666_6666);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_0020; if_flush = 1'b1;
    #1;
    chk("flush_idle_block", 64'(if_req_ready), 64'h0);
    @(negedge clk);
    if_flush = 1'b0;
    do_accept(1'b0, "fl");
    if_req_valid = 1'b0;
    @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    wait_quiet("fl");
    chk("fl_mem_completed", 64'(rsp_count - prev_rsp), 64'h1);

    // Flush coinciding with the memory response also suppresses it.
    rsp_lat = 0;
    mem_data_q.push_back(64'h7777_7777_8888_8888);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_0030;
    do_accept(1'b0, "flrsp");
    if_req_valid = 1'b0;
    @(negedge clk);
    if_flush = 1'b1;
    @(negedge clk);
    if_flush = 1'b0;
    wait_quiet("flrsp");

    // Next fetch after the flushes returns normally.
    rsp_lat = 1;
    mem_data_q.push_back(64'hAAAA_AAAA_BBBB_BBBB);
    if_q.push_back(32'hBBBB_BBBB);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_0100;
    do_accept(1'b0, "postfl");
    if_req_valid = 1'b0;
    wait_quiet("postfl");

    // Reset while waiting on an LS read discards it.
    rsp_lat = 20;
    mem_data_q.push_back(64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    ls_req_valid = 1'b1; ls_req_wen = 1'b0; ls_addr = 64'h8000_3000;
    do_accept(1'b1, "rstls");
    ls_req_valid = 1'b0;
    @(negedge clk);
    chk("rstls_busy_pre", 64'(busy), 64'h1);
    rstn = 1'b0;
    @(negedge clk);
    #1;
    chk_all_zero("rstls");
    @(negedge clk);
    mem_data_q.delete();
    rstn = 1'b1;

    rsp_lat = 1;
    mem_data_q.push_back(64'h0BAD_F00D_1357_2468);
    if_q.push_back(32'h1357_2468);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_0040;
    do_accept(1'b0, "postrst");
    if_req_valid = 1'b0;
    wait_quiet("postrst");

    // Back-to-back fetches with 1-cycle memory: next accept overlaps the response pulse.
    rsp_lat = 0;
    mem_data_q.push_back(64'h0000_0001_0000_0002);
    mem_data_q.push_back(64'h0000_0003_0000_0004);
    if_q.push_back(32'h0000_0002);
    if_q.push_back(32'h0000_0003);
    @(negedge clk);
    if_req_valid = 1'b1; if_addr = 64'h8000_0200;
    do_accept(1'b0, "b2b_a");
    if_addr = 64'h8000_0204;
    gap = 0;
    for (int k = 0; k < 10; k++) begin
      gap++;
      #1;
      if (if_req_ready) break;
      @(negedge clk);
    end
    chk("b2b_gap", 64'(gap), 64'h3);
    chk("b2b_overlap_rsp", 64'(if_rsp_valid), 64'h1);
    @(posedge clk);
    @(negedge clk);
    if_req_valid = 1'b0;
    wait_quiet("b2b");

    repeat (3) @(negedge clk);
    chk("end_if_q", 64'(if_q.size()), 64'h0);
    chk("end_ls_q", 64'(ls_q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
